// File: rtl/exe_pkg.sv
// Shared execution-unit definitions: operation codes, status width and the result entry layout.
package exe_pkg;

    localparam int OPER_BITS = 2;
    localparam int STATUS_W  = 4;
    localparam int EXE_WIDTH = 32;

    // Kept in step with the ALU operation encoding.
    localparam logic [OPER_BITS:0] ALU_ADD  = 3'd0;
    localparam logic [OPER_BITS:0] ALU_COMP = 3'd1;
    localparam logic [OPER_BITS:0] ALU_CONV = 3'd2;
    localparam logic [OPER_BITS:0] ALU_SET  = 3'd3;

    typedef struct packed {
        logic [OPER_BITS:0]    oper;
        logic [EXE_WIDTH-1:0]  result;
        logic [STATUS_W-1:0]   status;
        logic                  carry;
        logic                  err;
    } exe_entry_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } head_state_t;

endpackage

// File: rtl/exe_result_fifo_if.sv
// Producer/consumer/status bundle of the execution result FIFO; slave is the FIFO side.
interface exe_result_fifo_if
    import exe_pkg::*;
#(
    parameter int WIDTH    = EXE_WIDTH,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 8
);
    logic                       i_valid;
    logic [OPER_BITS:0]         i_oper;
    logic [WIDTH-1:0]           i_result;
    logic [STATUS_W-1:0]        i_status;
    logic                       i_carry;
    logic                       i_error_konw;
    logic                       i_error_ust;
    logic                       o_valid;
    logic                       i_ready;
    logic [WIDTH-1:0]           o_result;
    logic [OPER_BITS:0]         o_oper;
    logic [STATUS_W-1:0]        o_status;
    logic                       o_carry;
    logic                       o_error;
    logic [$clog2(DEPTH):0]     o_level;
    logic                       o_full;
    logic                       o_overflow;
    logic                       i_clr;
    logic [CNT_BITS-1:0]        o_err_cnt;

    modport slave (
        input  i_valid, i_oper, i_result, i_status, i_carry, i_error_konw, i_error_ust,
        input  i_ready, i_clr,
        output o_valid, o_result, o_oper, o_status, o_carry, o_error,
        output o_level, o_full, o_overflow, o_err_cnt
    );

    modport master (
        output i_valid, i_oper, i_result, i_status, i_carry, i_error_konw, i_error_ust,
        output i_ready, i_clr,
        input  o_valid, o_result, o_oper, o_status, o_carry, o_error,
        input  o_level, o_full, o_overflow, o_err_cnt
    );
endinterface

// File: rtl/exe_fifo_mem.sv
// DEPTH x W entry storage: one synchronous write port, one combinational read port.
module exe_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/exe_result_fifo.sv
// Execution result FIFO with registered head, sticky overflow and saturating error counter.
// Build option EXE_RES_ERR_FILTER_EN: error results are only counted, never stored.
module exe_result_fifo
    import exe_pkg::*;
#(
    parameter int WIDTH    = EXE_WIDTH,   // must match EXE_WIDTH of the entry layout
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 8
) (
    input  logic              i_clk,
    input  logic              i_rsn,
    exe_result_fifo_if.slave  bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int ENTRY_W = OPER_BITS + 1 + WIDTH + STATUS_W + 2;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    level_q, level_d;
    logic                full_q, ovf_q, ovf_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    head_state_t         state_q;
    exe_entry_t          head_q, wr_entry, rd_entry;
    logic                entry_err, push_req, push, pop, drop, cnt_evt;

    assign entry_err = bus.i_error_konw | bus.i_error_ust;
    assign wr_entry  = '{oper: bus.i_oper, result: bus.i_result, status: bus.i_status,
                         carry: bus.i_carry, err: entry_err};
    assign pop       = (state_q == HOLD) & bus.i_ready;

`ifdef EXE_RES_ERR_FILTER_EN
    assign push_req  = bus.i_valid & ~entry_err;
    assign cnt_evt   = bus.i_valid & entry_err;
`else
    assign push_req  = bus.i_valid;
    assign cnt_evt   = push & entry_err;
`endif
    assign push      = push_req & (~full_q | pop);
    assign drop      = push_req & full_q & ~pop;

    assign wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    assign level_d   = wr_ptr_d - rd_ptr_d;

    exe_fifo_mem #(.W(ENTRY_W), .DEPTH(DEPTH)) u_mem (
        .clk_i   (i_clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_d[IDX_W-1:0]),
        .rdata_o (rd_entry)
    );

    always_comb begin
        ovf_d = ovf_q | drop;
        cnt_d = cnt_q;
        if (cnt_evt && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
        if (bus.i_clr) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == PTR_W'(DEPTH));
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // With one entry left, a reload must take the word being written this cycle.
    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            state_q <= EMPTY;
            head_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q <= HOLD;
                        head_q  <= wr_entry;
                    end
                end
                HOLD: begin
                    if (pop) begin
                        if (level_d == '0) begin
                            state_q <= EMPTY;
                            head_q  <= '0;
                        end else if (level_q == PTR_W'(1)) begin
                            head_q  <= wr_entry;
                        end else begin
                            head_q  <= rd_entry;
                        end
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    head_q  <= '0;
                end
            endcase
        end
    end

    assign bus.o_valid    = (state_q == HOLD);
    assign bus.o_result   = head_q.result;
    assign bus.o_oper     = head_q.oper;
    assign bus.o_status   = head_q.status;
    assign bus.o_carry    = head_q.carry;
    assign bus.o_error    = head_q.err;
    assign bus.o_level    = level_q;
    assign bus.o_full     = full_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_err_cnt  = cnt_q;
endmodule

// File: tb/tb_exe_result_fifo.sv
// Scoreboard bench for exe_result_fifo: directed pushes queue expected entries, a monitor checks the head.
module tb_exe_result_fifo;
    import exe_pkg::*;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int CNT_BITS = 3;
`ifdef EXE_RES_ERR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) bus ();

    exe_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .i_clk (clk),
        .i_rsn (rst),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [40:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: head must match the oldest expected entry; popped on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_head: got 0x%0h expected no entry at %0t",
                             {bus.o_oper, bus.o_result, bus.o_status, bus.o_carry, bus.o_error}, $time);
                end else if (bus.i_ready) begin
                    check("head_pop", 64'({bus.o_oper, bus.o_result, bus.o_status, bus.o_carry, bus.o_error}),
                          64'(exp_q.pop_front()));
                end else begin
                    check("head_hold", 64'({bus.o_oper, bus.o_result, bus.o_status, bus.o_carry, bus.o_error}),
                          64'(exp_q[0]));
                end
            end else begin
                check("idle_zero", 64'({bus.o_oper, bus.o_result, bus.o_status, bus.o_carry, bus.o_error}), 64'd0);
            end
        end
    end

    task automatic do_push(input logic [2:0] op, input logic [31:0] res, input logic [3:0] st,
                           input logic c, input logic ek, input logic eu, input bit store);
        bus.i_valid      = 1'b1;
        bus.i_oper       = op;
        bus.i_result     = res;
        bus.i_status     = st;
        bus.i_carry      = c;
        bus.i_error_konw = ek;
        bus.i_error_ust  = eu;
        if (store && !(FILT && (ek | eu))) exp_q.push_back({op, res, st, c, ek | eu});
        @(posedge clk);
        #1;
        bus.i_valid      = 1'b0;
        bus.i_error_konw = 1'b0;
        bus.i_error_ust  = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.i_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.i_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !bus.o_valid) break;
            @(posedge clk);
            #1;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_level0"}, 64'(bus.o_level), 64'd0);
    endtask

    localparam logic [2:0] SAT_TBL [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0; bus.i_oper = '0; bus.i_result = '0; bus.i_status = '0;
        bus.i_carry = 1'b0; bus.i_error_konw = 1'b0; bus.i_error_ust = 1'b0;
        bus.i_ready = 1'b0; bus.i_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_level", 64'(bus.o_level), 64'd0);
        check("rst_full", 64'(bus.o_full), 64'd0);
        check("rst_ovf", 64'(bus.o_overflow), 64'd0);
        check("rst_cnt", 64'(bus.o_err_cnt), 64'd0);
        check("rst_result", 64'(bus.o_result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-stream
        do_push(ALU_ADD,  32'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_push(ALU_COMP, 32'h2, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1);
        do_push(ALU_SET,  32'h3, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_level", 64'(bus.o_level), FILT ? 64'd2 : 64'd3);
        check("mid_cnt", 64'(bus.o_err_cnt), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
        check("mid_rst_level", 64'(bus.o_level), 64'd0);
        check("mid_rst_cnt", 64'(bus.o_err_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single pass with latency 1
        bus.i_ready = 1'b1;
        do_push(ALU_ADD, 32'h0000_00A5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("single_valid", 64'(bus.o_valid), 64'd1);
        check("single_result", 64'(bus.o_result), 64'h0000_00A5);
        check("single_carry", 64'(bus.o_carry), 64'd1);
        @(posedge clk);
        #1;
        check("single_valid_after", 64'(bus.o_valid), 64'd0);
        check("single_level_after", 64'(bus.o_level), 64'd0);

        // Fill and overflow
        bus.i_ready = 1'b0;
        for (int i = 1; i <= 4; i++) do_push(ALU_COMP, 32'(i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        check("fill_full", 64'(bus.o_full), 64'd1);
        check("fill_level", 64'(bus.o_level), 64'd4);
        check("fill_ovf0", 64'(bus.o_overflow), 64'd0);
        do_push(ALU_COMP, 32'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_ovf", 64'(bus.o_overflow), 64'd1);
        check("drop_level", 64'(bus.o_level), 64'd4);
        wait_drain("fill");
        check("fill_full_after", 64'(bus.o_full), 64'd0);
        check("ovf_sticky", 64'(bus.o_overflow), 64'd1);
        clr_pulse();
        check("ovf_cleared", 64'(bus.o_overflow), 64'd0);

        // Push and pop while full, across pointer wrap
        bus.i_ready = 1'b0;
        for (int i = 11; i <= 14; i++) do_push(ALU_CONV, 32'(i), 4'hC, 1'b1, 1'b0, 1'b0, 1'b1);
        check("pp_full", 64'(bus.o_full), 64'd1);
        bus.i_ready = 1'b1;
        for (int i = 15; i <= 17; i++) begin
            do_push(ALU_CONV, 32'(i), 4'hD, 1'b0, 1'b0, 1'b0, 1'b1);
            check("pp_level", 64'(bus.o_level), 64'd4);
            check("pp_full_hold", 64'(bus.o_full), 64'd1);
            check("pp_no_ovf", 64'(bus.o_overflow), 64'd0);
        end
        wait_drain("pp");

        // Error counter saturation and clear priority
        clr_pulse();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            do_push(ALU_CONV, 32'h100 + 32'(i), 4'h5, 1'b0, 1'(i == 1), 1'(i != 1), 1'b1);
            check("err_cnt", 64'(bus.o_err_cnt), 64'(SAT_TBL[i]));
        end
        bus.i_clr = 1'b1;
        do_push(ALU_ADD, 32'h1FF, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.i_clr = 1'b0;
        check("clr_wins", 64'(bus.o_err_cnt), 64'd0);
        wait_drain("err");
        check("err_no_ovf", 64'(bus.o_overflow), 64'd0);

        // Alternating error / clean pushes
        clr_pulse();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_push(ALU_SET, 32'h200 + 32'(i), 4'hA, 1'(i & 1), 1'b0, 1'((i & 1) == 0), 1'b1);
        end
        wait_drain("alt");
        check("alt_cnt", 64'(bus.o_err_cnt), 64'd4);
        check("alt_no_ovf", 64'(bus.o_overflow), 64'd0);

`ifdef EXE_RES_ERR_FILTER_EN
        // Filtered errors never overflow a full FIFO
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_push(ALU_ADD, 32'h300 + 32'(i), 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_push(ALU_ADD, 32'h3FF, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("filt_full_no_ovf", 64'(bus.o_overflow), 64'd0);
        check("filt_full_cnt", 64'(bus.o_err_cnt), 64'd5);
        wait_drain("filt");
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/exe_result_fifo.md
Name: exe_result_fifo

Overview:
- Downstream stage of the execution unit.
- Captures each registered result word with its operation code, status nibble, carry and error flags into a small synchronous FIFO, then presents entries to the consumer over a valid/ready handshake.
- Also keeps a saturating error-event counter and a sticky overflow flag for software status readout.

Parameters:
- WIDTH, 32: result width; must equal the execution unit's WIDTH.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_BITS, 8: width of the error-event counter.

Ports:
- i_clk, input, 1: clock; all state updates on its rising edge.
- i_rsn, input, 1: reset, asynchronous, active-high.
- i_valid, input, 1: the execution unit presents a new result this cycle.
- i_oper, input, OPER_BITS+1: operation code that produced the result.
- i_result, input, WIDTH: result word.
- i_status, input, 4: status flags from the execution unit.
- i_carry, input, 1: carry out.
- i_error_konw, input, 1: conversion error.
- i_error_ust, input, 1: set-operation error.
- o_valid, output, 1: head entry available.
- i_ready, input, 1: consumer accepts the head entry when o_valid=1.
- o_result, output, WIDTH: head entry result.
- o_oper, output, OPER_BITS+1: head entry operation code.
- o_status, output, 4: head entry status.
- o_carry, output, 1: head entry carry.
- o_error, output, 1: head entry error, the OR of the two error inputs at capture.
- o_level, output, $clog2(DEPTH)+1: current occupancy.
- o_full, output, 1: occupancy equals DEPTH.
- o_overflow, output, 1: sticky; a push was dropped.
- i_clr, input, 1: synchronous clear of o_overflow and o_err_cnt.
- o_err_cnt, output, CNT_BITS: saturating count of accepted entries with error=1.

Behaviour:
- Reset (asynchronous, active-high):
  - Read and write pointers = 0; o_level = 0; o_valid = 0; o_full = 0; o_overflow = 0; o_err_cnt = 0.
  - o_result, o_oper, o_status, o_carry and o_error all = 0.
- Reset asserted mid-operation discards all stored entries immediately, with no handshake completion.
- Push:
  - Condition: i_valid=1 and (not full, or a pop happens in the same cycle).
  - Writes {oper, result, status, carry, err} at the write pointer; the write pointer increments modulo DEPTH.
- Pop: o_valid=1 and i_ready=1; the read pointer increments modulo DEPTH.
- Output registers:
  - Head outputs are registered.
  - A push into an empty FIFO gives o_valid=1 on the next cycle (latency 1, no same-cycle bypass).
  - Head outputs hold stable while o_valid=1 and i_ready=0.
  - Head outputs are 0 whenever o_valid=0.
- Occupancy:
  - o_level = level + push - pop.
  - o_full = (o_level == DEPTH).
  - Both update in the cycle after the push or pop.
- Full with a simultaneous pop: the push is accepted, the level is unchanged and there is no overflow.
- Full without a pop and i_valid=1: the entry is dropped and o_overflow is set on the next cycle; it stays set until i_clr or reset.
- Empty with i_ready=1: no effect, the level stays 0.
- Wrap-around: pointers carry an extra MSB so full and empty are distinguished when the pointers are equal.
- Error counter:
  - Increments by 1 per accepted push with err=1.
  - Saturates at 2^CNT_BITS-1; no wrap.
  - Dropped pushes are not counted.
- i_clr:
  - Clears o_overflow and o_err_cnt.
  - If i_clr coincides with a counting push, the clear wins and the count = 0.
  - The FIFO contents are unaffected.
- Control structure: the head register is a 2-state FSM, EMPTY and HOLD.
  - EMPTY goes to HOLD when the level becomes nonzero.
  - HOLD goes to EMPTY on a pop that leaves the level at 0.
  - HOLD reloads the next entry on a pop when the level stays nonzero.

Optional Feature:
- Macro: EXE_RES_ERR_FILTER_EN.
- When defined, a push with err=1 is not written to the FIFO. It is counted in o_err_cnt only, subject to the same saturation rules. It never sets o_overflow, even when the FIFO is full.
- When undefined, error entries are stored like any other entry, and o_error reflects them.

Decomposition:
- Shared package exe_pkg holds:
  - OPER_BITS and the ALU_ADD/ALU_COMP/ALU_CONV/ALU_SET codes, in step with alu_defines.
  - typedef exe_entry_t, a packed struct {oper, result, status, carry, err} parameterised by WIDTH.
  - STATUS_W = 4.
- One natural sub-module: exe_fifo_mem, the DEPTH x entry register array with write port and read address. Pointers, FSM and counters stay in the top.

Test Plan:
- Reset mid-stream: push 3 entries, assert i_rsn between edges -> o_valid=0, o_level=0 and o_err_cnt=0 immediately.
- Single pass: push result 0x0000_00A5 with oper=ALU_ADD and carry=1, with i_ready=1 -> o_valid=1 one cycle later with the same fields, then o_level returns to 0.
- Fill and overflow with DEPTH=4: push 5 entries with i_ready=0 -> o_full=1 after the 4th, the 5th is dropped, o_overflow=1, and draining yields exactly entries 1..4 in order.
- Push and pop while full: i_valid=1 and i_ready=1 with o_full=1 -> level stays 4, no overflow, order preserved across pointer wrap.
- Error counter with CNT_BITS=2: 5 pushes with i_error_ust=1 -> o_err_cnt=3 (saturated); i_clr together with an error push -> o_err_cnt=0.
- With EXE_RES_ERR_FILTER_EN: alternate error and clean pushes (4 of each) -> only the 4 clean entries are drained and o_err_cnt=4.
